// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, issues reads to a 1-cycle
// synchronous ROM and buffers returned instructions in a small prefetch FIFO.
module instruction_fetch #(
  parameter int COUNTER_WIDTH     = 8,
  parameter int INSTRUCTION_WIDTH = 11,
  parameter int DEPTH             = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [COUNTER_WIDTH-1:0]     mem_addr,
  output logic                         mem_read,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [COUNTER_WIDTH-1:0]     instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  input  logic                         redirect,
  input  logic [COUNTER_WIDTH-1:0]     redirect_pc,
  output logic [$clog2(DEPTH):0]       occupancy
);

  localparam int PW = $clog2(DEPTH);

  logic [COUNTER_WIDTH-1:0]     pc;
  logic [COUNTER_WIDTH-1:0]     inflight_pc;
  logic                         inflight;
  logic [INSTRUCTION_WIDTH-1:0] data_q [DEPTH];
  logic [COUNTER_WIDTH-1:0]     tag_q  [DEPTH];
  logic [PW-1:0]                rd_ptr;
  logic [PW-1:0]                wr_ptr;
  logic [PW:0]                  count;
  logic [PW+1:0]                pending;
  logic                         push;
  logic                         pop;

  // Every issued read has a FIFO slot reserved for it, so a capture can never
  // find the FIFO full; pops in the same cycle are deliberately not credited.
  always_comb begin
    pending     = {1'b0, count} + (PW+2)'(inflight);
    mem_read    = !reset && !redirect && (pending < (PW+2)'(DEPTH));
    mem_addr    = pc;
    instr_valid = (count != '0);
    push        = inflight && !redirect;
    pop         = instr_valid && instr_ready && !redirect;
    instr       = instr_valid ? data_q[rd_ptr] : '0;
    instr_pc    = instr_valid ? tag_q[rd_ptr]  : '0;
    occupancy   = count;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      // A redirect drops buffered entries, the pending pop and the read in flight.
      pc          <= redirect_pc;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (mem_read) pc <= pc + COUNTER_WIDTH'(1);
      inflight    <= mem_read;
      inflight_pc <= pc;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count and the
  // pointers, and leaving the array unreset lets it map onto plain RAM cells.
  always_ff @(posedge clock) begin
    if (push) begin
      data_q[wr_ptr] <= mem_data;
      tag_q[wr_ptr]  <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed latency/flush scenarios plus random
// ready/redirect/reset traffic, checked by an in-order scoreboard of ROM[pc].
module tb_instruction_fetch;

  localparam int CW    = 8;
  localparam int IW    = 11;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] mem_addr;
  logic          mem_read;
  logic [IW-1:0] mem_data = '0;
  logic [IW-1:0] instr;
  logic [CW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [CW-1:0] redirect_pc = '0;
  logic [$clog2(DEPTH):0] occupancy;

  instruction_fetch #(.COUNTER_WIDTH(CW), .INSTRUCTION_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  // Synchronous ROM with one cycle of read latency.
  logic [IW-1:0] rom [256];
  always @(posedge clock) if (mem_read) mem_data <= rom[mem_addr];

  typedef struct packed {
    logic [CW-1:0] pc;
    logic [IW-1:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  int   seg    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // After reset or redirect the stream must be start, start+1, ... mod 256.
  task automatic restart(input logic [CW-1:0] start);
    sb.delete();
    for (int i = 0; i < 300; i++) begin
      logic [CW-1:0] a;
      a = start + CW'(i);
      sb.push_back('{pc: a, instr: rom[a]});
    end
    seg = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: consumes one expected entry per handshake, checks head stability.
  logic          hold = 1'b0;
  logic [CW-1:0] hold_pc;
  logic [IW-1:0] hold_instr;

  always @(negedge clock) begin
    if (hold) begin
      check("hold_valid", instr_valid, 1'b1);
      check("hold_pc", instr_pc, hold_pc);
      check("hold_instr", instr, hold_instr);
    end
    hold = 1'b0;
    if (!reset && !redirect && instr_valid) begin
      if (instr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got pc 0x%0h, expected no output", instr_pc);
        end else begin
          e = sb.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", instr, e.instr);
          pops++;
        end
      end else begin
        hold       = 1'b1;
        hold_pc    = instr_pc;
        hold_instr = instr;
      end
    end
  end

  initial begin
    logic          found;
    logic [CW-1:0] wrap_seq [3];
    bit            rs, rd;
    int            pops_before;

    for (int i = 0; i < 256; i++) rom[i] = IW'(i + 'h100);

    // Reset state
    repeat (3) step();
    #1;
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_occupancy", occupancy, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);

    // 1: first fetch latency and back-to-back streaming
    step();
    reset = 1'b0;
    instr_ready = 1'b1;
    restart(8'h00);
    #1;
    check("t1_issue", mem_read, 1'b1);
    check("t1_addr0", mem_addr, 8'h00);
    check("t1_valid_c0", instr_valid, 1'b0);
    step(); #1;
    check("t1_valid_c1", instr_valid, 1'b0);
    check("t1_addr1", mem_addr, 8'h01);
    step(); #1;
    check("t1_valid_c2", instr_valid, 1'b1);
    check("t1_instr", instr, 11'h100);
    check("t1_pc", instr_pc, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      check("t1_stream_valid", instr_valid, 1'b1);
    end

    // 2: stall until full, then drain without gaps
    step();
    instr_ready = 1'b0;
    repeat (10) step();
    #1;
    check("t2_occ_full", occupancy, DEPTH);
    check("t2_read_off", mem_read, 1'b0);
    check("t2_valid", instr_valid, 1'b1);
    step();
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t2_drain_valid", instr_valid, 1'b1);
      step();
    end

    // 3: redirect while nearly full with a read in flight
    instr_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(); #1;
      if (occupancy == 3 && !mem_read) found = 1'b1;
    end
    check("t3_precondition", found, 1'b1);
    redirect = 1'b1;
    redirect_pc = 8'h40;
    restart(8'h40);
    #1;
    check("t3_read_blocked", mem_read, 1'b0);
    step();
    redirect = 1'b0;
    #1;
    check("t3_issue", mem_read, 1'b1);
    check("t3_addr", mem_addr, 8'h40);
    check("t3_flushed_valid", instr_valid, 1'b0);
    check("t3_flushed_occ", occupancy, 0);
    step(); #1;
    check("t3_n2_valid", instr_valid, 1'b0);
    step(); #1;
    check("t3_n3_valid", instr_valid, 1'b1);
    check("t3_n3_pc", instr_pc, 8'h40);
    check("t3_n3_instr", instr, rom[8'h40]);

    // 4: pc wraps from 0xFF to 0x00
    step();
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    instr_ready = 1'b1;
    restart(8'hFE);
    step();
    redirect = 1'b0;
    step();
    step(); #1;
    check("t4_valid", instr_valid, 1'b1);
    check("t4_pc_fe", instr_pc, 8'hFE);
    wrap_seq[0] = 8'hFF;
    wrap_seq[1] = 8'h00;
    wrap_seq[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      check("t4_wrap_pc", instr_pc, wrap_seq[i]);
    end

    // 5: reset mid-stream
    step(); #1;
    check("t5_pre_valid", instr_valid, 1'b1);
    reset = 1'b1;
    restart(8'h00);
    #1;
    check("t5_read_in_reset", mem_read, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("t5_valid", instr_valid, 1'b0);
    check("t5_occ", occupancy, 0);
    check("t5_issue", mem_read, 1'b1);
    check("t5_addr", mem_addr, 8'h00);
    repeat (6) step();

    // 6: random ready, redirects and resets against the scoreboard
    reset = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
    step();
    step();
    reset = 1'b0;
    restart(8'h00);
    pops_before = pops;
    for (int c = 0; c < 3000; c++) begin
      step();
      instr_ready = ($urandom_range(3) != 0);
      rs = ($urandom_range(149) == 0);
      rd = ($urandom_range(24) == 0) || (seg > 200);
      reset = rs;
      redirect = rd;
      redirect_pc = CW'($urandom);
      if (rs) restart(8'h00);
      else if (rd) restart(redirect_pc);
      seg++;
    end
    step();
    reset = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b1;
    repeat (10) step();
    check("t6_progress", (pops - pops_before) > 500, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
